// File: rtl/hazard_stall_ctrl.sv
// Stall/flush control for the D->E pipeline register: GPR read-after-write
// hazards via the Tuse/Tnew rule plus a multiply/divide busy-window interlock.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs_number,
    input  logic [4:0] D_rt_number,
    input  logic [1:0] D_rs_tuse,
    input  logic [1:0] D_rt_tuse,
    input  logic       D_is_md,
    input  logic [4:0] E_REG_write_number,
    input  logic       E_REG_write_enable,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_REG_write_number,
    input  logic       M_REG_write_enable,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       E_md_is_div,
    output logic       stall,
    output logic       DE_flush,
    output logic       md_busy
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] md_count_q;
    logic [CNT_W-1:0] md_count_d;
    logic             md_nonzero;
    logic             e_hit_rs;
    logic             m_hit_rs;
    logic             e_hit_rt;
    logic             m_hit_rt;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;

    assign md_nonzero = (md_count_q != '0);

    always_comb begin
        e_hit_rs = E_REG_write_enable && (E_REG_write_number == D_rs_number) && (D_rs_tuse < E_tnew);
        m_hit_rs = M_REG_write_enable && (M_REG_write_number == D_rs_number) && (D_rs_tuse < M_tnew);
        e_hit_rt = E_REG_write_enable && (E_REG_write_number == D_rt_number) && (D_rt_tuse < E_tnew);
        m_hit_rt = M_REG_write_enable && (M_REG_write_number == D_rt_number) && (D_rt_tuse < M_tnew);

        // $0 is hardwired and tuse==3 means the operand is not read at all
        stall_rs = (D_rs_number != 5'd0) && (D_rs_tuse != 2'd3) && (e_hit_rs || m_hit_rs);
        stall_rt = (D_rt_number != 5'd0) && (D_rt_tuse != 2'd3) && (e_hit_rt || m_hit_rt);
        stall_md = D_is_md && (E_md_start || md_nonzero);

        stall    = stall_rs || stall_rt || stall_md;
        DE_flush = stall;
        md_busy  = md_nonzero;
    end

    // A start while already counting is ignored; the countdown saturates at 0
    always_comb begin
        md_count_d = md_count_q;
        if (E_md_start && !md_nonzero) begin
            md_count_d = E_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_nonzero) begin
            md_count_d = md_count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_count_q <= '0;
        end else begin
            md_count_q <= md_count_d;
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios then random traffic, checked
// against a model that tracks the MDU busy window as an absolute end cycle.
module tb_hazard_stall_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic       clk;
    logic       reset;
    logic [4:0] D_rs_number;
    logic [4:0] D_rt_number;
    logic [1:0] D_rs_tuse;
    logic [1:0] D_rt_tuse;
    logic       D_is_md;
    logic [4:0] E_REG_write_number;
    logic       E_REG_write_enable;
    logic [1:0] E_tnew;
    logic [4:0] M_REG_write_number;
    logic       M_REG_write_enable;
    logic [1:0] M_tnew;
    logic       E_md_start;
    logic       E_md_is_div;
    logic       stall;
    logic       DE_flush;
    logic       md_busy;

    int compared;
    int mismatched;
    int cyc;
    int busy_end;
    int illegal_seen;

    hazard_stall_ctrl #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .D_rs_number       (D_rs_number),
        .D_rt_number       (D_rt_number),
        .D_rs_tuse         (D_rs_tuse),
        .D_rt_tuse         (D_rt_tuse),
        .D_is_md           (D_is_md),
        .E_REG_write_number(E_REG_write_number),
        .E_REG_write_enable(E_REG_write_enable),
        .E_tnew            (E_tnew),
        .M_REG_write_number(M_REG_write_number),
        .M_REG_write_enable(M_REG_write_enable),
        .M_tnew            (M_tnew),
        .E_md_start        (E_md_start),
        .E_md_is_div       (E_md_is_div),
        .stall             (stall),
        .DE_flush          (DE_flush),
        .md_busy           (md_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // An operand must wait while it is needed sooner than a pending writer produces it
    function automatic logic reg_waits(input logic [4:0] num, input logic [1:0] tuse);
        int need;
        need = tuse;
        if (num == 5'd0 || tuse == 2'd3) return 1'b0;
        if (E_REG_write_enable && E_REG_write_number == num && need < int'(E_tnew)) return 1'b1;
        if (M_REG_write_enable && M_REG_write_number == num && need < int'(M_tnew)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_idle();
        D_rs_number = '0; D_rt_number = '0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
        D_is_md = 1'b0;
        E_REG_write_number = '0; E_REG_write_enable = 1'b0; E_tnew = '0;
        M_REG_write_number = '0; M_REG_write_enable = 1'b0; M_tnew = '0;
        E_md_start = 1'b0; E_md_is_div = 1'b0;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Inputs are already stable for this cycle; check outputs, then step over the edge.
    task automatic run_cycle(input string tag);
        logic busy_e;
        logic stall_e;
        #3;
        busy_e  = (cyc <= busy_end);
        stall_e = reg_waits(D_rs_number, D_rs_tuse) || reg_waits(D_rt_number, D_rt_tuse)
                  || (D_is_md && (E_md_start || busy_e));
        check_bit({tag, ".stall"}, stall, stall_e);
        check_bit({tag, ".flush"}, DE_flush, stall_e);
        check_bit({tag, ".busy"}, md_busy, busy_e);
        @(posedge clk);
        if (reset) begin
            busy_end = cyc;
        end else if (E_md_start && !busy_e) begin
            busy_end = cyc + (E_md_is_div ? DIV_N : MULT_N);
        end
        cyc++;
        #1;
    endtask

    initial begin
        compared     = 0;
        mismatched   = 0;
        illegal_seen = 0;
        cyc          = 0;
        busy_end     = -1;
        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_cycle("reset_idle");
        reset = 1'b0;
        run_cycle("idle");

        // E-stage RAW on rs
        E_REG_write_enable = 1'b1; E_REG_write_number = 5'd8; E_tnew = 2'd2;
        D_rs_number = 5'd8; D_rs_tuse = 2'd1;
        run_cycle("e_raw_rs_tuse1");
        D_rs_tuse = 2'd2;
        run_cycle("e_raw_rs_tuse2");
        D_rs_tuse = 2'd3; D_rs_number = 5'd8;
        run_cycle("e_raw_rs_unused");
        set_idle();

        // M-stage RAW on rt, then $0 never hazards
        M_REG_write_enable = 1'b1; M_REG_write_number = 5'd9; M_tnew = 2'd1;
        D_rt_number = 5'd9; D_rt_tuse = 2'd0;
        run_cycle("m_raw_rt");
        M_REG_write_number = 5'd0; D_rt_number = 5'd0;
        run_cycle("m_raw_zero");
        M_REG_write_number = 5'd9; D_rt_number = 5'd9; M_REG_write_enable = 1'b0;
        run_cycle("m_raw_we0");
        set_idle();

        // mult then div busy windows with an mfhi held in D
        for (int v = 0; v < 2; v++) begin
            D_is_md = 1'b1; E_md_start = 1'b1; E_md_is_div = (v == 1);
            run_cycle(v == 1 ? "div_c0" : "mult_c0");
            E_md_start = 1'b0;
            for (int i = 1; i <= DIV_N + 2; i++) run_cycle(v == 1 ? "div_win" : "mult_win");
        end

        // reset in the middle of a divide
        E_md_start = 1'b1; E_md_is_div = 1'b1;
        run_cycle("rst_div_c0");
        E_md_start = 1'b0;
        for (int i = 1; i <= 3; i++) run_cycle("rst_div_run");
        reset = 1'b1;
        run_cycle("rst_div_c4");
        reset = 1'b0;
        run_cycle("rst_div_c5");
        run_cycle("rst_div_c6");

        // start pulsed inside a running divide must be ignored
        E_md_start = 1'b1; E_md_is_div = 1'b1;
        run_cycle("ill_c0");
        E_md_start = 1'b0;
        for (int i = 1; i <= DIV_N + 2; i++) begin
            E_md_start = (i == 3); E_md_is_div = 1'b0;
            if (i == 3) begin
                #2;
                if (E_md_start && md_busy === 1'b1) illegal_seen++;
            end
            run_cycle("ill_run");
        end
        compared++;
        assert (illegal_seen === 1) else begin
            mismatched++;
            $error("FAIL illegal_start_flag: observed %0d expected %0d", illegal_seen, 1);
        end
        set_idle();

        // random traffic over a small register window to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            reset              = ($urandom_range(0, 63) == 0);
            D_rs_number        = 5'($urandom_range(0, 3));
            D_rt_number        = 5'($urandom_range(0, 3));
            D_rs_tuse          = 2'($urandom_range(0, 3));
            D_rt_tuse          = 2'($urandom_range(0, 3));
            D_is_md            = ($urandom_range(0, 3) == 0);
            E_REG_write_number = 5'($urandom_range(0, 3));
            E_REG_write_enable = 1'($urandom_range(0, 1));
            E_tnew             = 2'($urandom_range(0, 2));
            M_REG_write_number = 5'($urandom_range(0, 3));
            M_REG_write_enable = 1'($urandom_range(0, 1));
            M_tnew             = 2'($urandom_range(0, 1));
            E_md_start         = ($urandom_range(0, 7) == 0);
            E_md_is_div        = 1'($urandom_range(0, 1));
            run_cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Producer of the stall/flush control consumed by the D→E pipeline register.
- Resolves read-after-write hazards between the D-stage reader and in-flight E/M-stage writers using the Tuse/Tnew rule.
- Tracks the multiply/divide unit's busy window with an internal countdown, so HI/LO-touching instructions hold in D.
- Outputs freeze PC and F/D register and insert a bubble into D/E.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- D_rs_number  input  5  rs register index read by D-stage instruction.
- D_rt_number  input  5  rt register index read by D-stage instruction.
- D_rs_tuse  input  2  cycles until rs value is needed (0..2; 3 = not used).
- D_rt_tuse  input  2  same for rt.
- D_is_md  input  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
- E_REG_write_number  input  5  destination of E-stage instruction.
- E_REG_write_enable  input  1  E-stage instruction writes GPR.
- E_tnew  input  2  cycles until E result is available (0..2).
- M_REG_write_number  input  5  destination of M-stage instruction.
- M_REG_write_enable  input  1  M-stage instruction writes GPR.
- M_tnew  input  2  cycles until M result is available (0..1).
- E_md_start  input  1  E-stage instruction launches mult/div this cycle.
- E_md_is_div  input  1  with E_md_start: 1 = div/divu, 0 = mult/multu.
- stall  output  1  freeze PC and F/D register.
- DE_flush  output  1  bubble into D/E register.
- md_busy  output  1  MDU countdown nonzero (registered state).

Behaviour:
- Single clock domain. Reset is synchronous and active-high. Registered state is one countdown md_count; its width is the bit width of max(MULT_CYCLES, DIV_CYCLES).
- Reset: md_count=0, so md_busy=0. The stall and DE_flush outputs are combinational and read 0 once the pipeline inputs are bubbles.
- Register hazard, rs: stall_rs = (D_rs_number!=0) & (D_rs_tuse!=3) & ((E_REG_write_enable & E_REG_write_number==D_rs_number & D_rs_tuse<E_tnew) | (M_REG_write_enable & M_REG_write_number==D_rs_number & D_rs_tuse<M_tnew)).
- Register hazard, rt: same rule using rt signals.
- Write enable low or write number 0: never a hazard.
- MDU hazard: stall_md = D_is_md & (E_md_start | md_count!=0).
- stall = stall_rs | stall_rt | stall_md.
- DE_flush = stall in the same cycle. D/E applies stall before flush, so this block never raises the D/E stall itself.
- Countdown, highest priority first:
  - reset → 0.
  - E_md_start & md_count==0 → load DIV_CYCLES if E_md_is_div, else MULT_CYCLES.
  - md_count!=0 → md_count−1.
  - otherwise hold at 0 (saturates, no wrap).
- E_md_start while md_count!=0 is ignored. The interlock makes it unreachable; the bench checks this with an assertion.
- md_busy = (md_count!=0), registered timing: first high in the cycle after the start cycle.
- Timing example, mult started in cycle t:
  - md_busy high cycles t+1..t+MULT_CYCLES.
  - A D-stage mfhi is stalled cycles t..t+MULT_CYCLES.
  - It is released at t+MULT_CYCLES+1.
- Combinational path from inputs to stall has no registers. Latency is 0 cycles, except the countdown, which updates 1 cycle after an edge.
- Reset mid-count clears md_count immediately at the edge; the next cycle has no MDU stall.

Test Plan:
- Reset, then all inputs 0 → stall=0, DE_flush=0, md_busy=0.
- E writes $8 (E_tnew=2, enable=1), D_rs_number=8, D_rs_tuse=1 → stall=1, DE_flush=1. Change D_rs_tuse to 2 → stall=0.
- M writes $9 (M_tnew=1), D_rt_number=9, D_rt_tuse=0 → stall=1. Same with write number 0 and D_rt_number=0 → stall=0.
- E_md_start=1, E_md_is_div=0 at cycle 0, D_is_md=1 held:
  - md_busy=1 cycles 1..5; stall=1 cycles 0..5.
  - stall=0 at cycle 6.
  - div variant: md_busy=1 cycles 1..10.
- Div started; reset asserted at cycle 4 → md_count=0 at cycle 5, md_busy=0, stall=0 with D_is_md=1.
- E_md_start pulsed at cycle 3 of a running div → countdown unaffected, md_busy falls after cycle 10, assertion flags the illegal start.
